// File: rtl/rd_addr_sched_pkg.sv
// Shared types and default sizes for the read-address scheduler.
package rd_addr_sched_pkg;

    localparam int DATA_W_DEF  = 64;
    localparam int DEPTH_W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/rd_addr_sched_rr_arb2.sv
// Two-way round-robin arbiter; the requester just served loses priority.
module rr_arb2 (
    input  logic       clk,
    input  logic       tb_rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);

    logic prio_q, prio_d;

    always_comb begin
        grant  = 2'b00;
        prio_d = prio_q;
        if (enable) begin
            if (!prio_q) begin
                if (req[0])      grant = 2'b01;
                else if (req[1]) grant = 2'b10;
            end else begin
                if (req[1])      grant = 2'b10;
                else if (req[0]) grant = 2'b01;
            end
        end
        if (grant[0])      prio_d = 1'b1;
        else if (grant[1]) prio_d = 1'b0;
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) prio_q <= 1'b0;
        else        prio_q <= prio_d;
    end

endmodule

// File: rtl/rd_addr_sched.sv
// Read-address scheduler: arbitrates two requesters into a FIFO and drains it to a read engine.
// Optional per-requester statistics are built when RD_ADDR_SCHED_STATS_EN is defined.
//
// state | meaning
// IDLE  | nothing in flight, waiting for the FIFO to become non-empty
// FETCH | FIFO read issued last cycle, capture fifo_rd_data this cycle
// HOLD  | out_valid asserted, waiting for out_ready
module rd_addr_sched
    import rd_addr_sched_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH_W = DEPTH_W_DEF
) (
    input  logic              clk,
    input  logic              tb_rst,
    input  logic [1:0]        req_valid,
    input  logic [DATA_W-1:0] req_addr0,
    input  logic [DATA_W-1:0] req_addr1,
    output logic [1:0]        req_ready,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic              fifo_wr_full,
    input  logic              fifo_almost_full,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [DEPTH_W:0]  level
`ifdef RD_ADDR_SCHED_STATS_EN
    ,
    output logic [15:0]       acc_cnt0,
    output logic [15:0]       acc_cnt1,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [DEPTH_W:0] LVL_MAX = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [DEPTH_W:0] LVL_ONE = {{DEPTH_W{1'b0}}, 1'b1};

    logic [1:0]        grant;
    logic              wr_enable;
    rd_state_e         state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              rd_en;
    logic [DEPTH_W:0]  level_q, level_d;

    assign wr_enable = ~fifo_almost_full & ~fifo_wr_full;

    rr_arb2 u_arb (
        .clk    (clk),
        .tb_rst (tb_rst),
        .req    (req_valid),
        .enable (wr_enable),
        .grant  (grant)
    );

    assign req_ready    = grant;
    assign fifo_wr_en   = |grant;
    assign fifo_wr_data = grant[1] ? req_addr1 : req_addr0;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rd_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_rd_empty) begin
                    rd_en   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                out_data_d  = fifo_rd_data;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (!fifo_rd_empty) begin
                        rd_en   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset gates the combinational read strobe so the FIFO never sees a read while it is being cleared.
    assign fifo_rd_en = rd_en & ~tb_rst;

    always_comb begin
        level_d = level_q;
        if (fifo_wr_en && !fifo_rd_en && level_q != LVL_MAX)
            level_d = level_q + LVL_ONE;
        else if (fifo_rd_en && !fifo_wr_en && level_q != '0)
            level_d = level_q - LVL_ONE;
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            level_q     <= level_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign level     = level_q;

`ifdef RD_ADDR_SCHED_STATS_EN
    logic [15:0] acc0_q, acc1_q, stall_q;
    logic        stall;

    assign stall = (|req_valid) & ~wr_enable;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            acc0_q  <= '0;
            acc1_q  <= '0;
            stall_q <= '0;
        end else begin
            if (grant[0] && acc0_q != 16'hFFFF)  acc0_q  <= acc0_q + 16'd1;
            if (grant[1] && acc1_q != 16'hFFFF)  acc1_q  <= acc1_q + 16'd1;
            if (stall && stall_q != 16'hFFFF)    stall_q <= stall_q + 16'd1;
        end
    end

    assign acc_cnt0  = acc0_q;
    assign acc_cnt1  = acc1_q;
    assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/rd_addr_sched.md
RD_ADDR_SCHED -- requirements
Module: rd_addr_sched

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning the read-address descriptor width.
REQ-002 The block SHALL have parameter DEPTH_W, default 6, meaning log2 of the FIFO depth (64 entries).
REQ-003 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 The block SHALL have port tb_rst, input, 1, the reset: asynchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, 2, per-requester descriptor valid.
REQ-006 The block SHALL have ports req_addr0 and req_addr1, input, DATA_W each, the requester descriptors.
REQ-007 The block SHALL have port req_ready, output, 2, per-requester accept (combinational).
REQ-008 The block SHALL have ports fifo_wr_en (output, 1), fifo_wr_data (output, DATA_W), fifo_wr_full (input, 1) and fifo_almost_full (input, 1), forming the FIFO write port.
REQ-009 The block SHALL have ports fifo_rd_en (output, 1), fifo_rd_data (input, DATA_W) and fifo_rd_empty (input, 1), forming the FIFO read port; fifo_rd_data is valid the cycle after fifo_rd_en.
REQ-010 The block SHALL have ports out_valid (output, 1), out_data (output, DATA_W) and out_ready (input, 1), forming the downstream read-engine handshake.
REQ-011 The block SHALL have port level, output, DEPTH_W+1, the tracked FIFO occupancy.

Function
REQ-012 The write side SHALL grant at most one requester per cycle, round-robin, and only when fifo_almost_full=0 and fifo_wr_full=0.
REQ-013 After a grant to requester i, the write side SHALL give priority to requester 1-i in the next arbitration; the initial priority SHALL be requester 0.
REQ-014 A grant SHALL drive req_ready[i]=1, fifo_wr_en=1 and fifo_wr_data=req_addrI in the same cycle; no grant SHALL drive fifo_wr_en=0.
REQ-015 The read FSM SHALL have three states: IDLE, FETCH and HOLD.
REQ-016 In IDLE with fifo_rd_empty=0, the FSM SHALL pulse fifo_rd_en and move to FETCH.
REQ-017 In FETCH, the FSM SHALL register fifo_rd_data into out_data, set out_valid=1 and move to HOLD.
REQ-018 In HOLD with out_ready=1 and fifo_rd_empty=0, the FSM SHALL pulse fifo_rd_en and move to FETCH, with out_valid dropping for one cycle.
REQ-019 In HOLD with out_ready=1 and fifo_rd_empty=1, the FSM SHALL clear out_valid and move to IDLE.
REQ-020 In HOLD with out_ready=0, out_data and out_valid SHALL hold.
REQ-021 fifo_rd_en SHALL never assert while fifo_rd_empty=1.
REQ-022 level SHALL increment on fifo_wr_en only, decrement on fifo_rd_en only, and stay unchanged when both assert in the same cycle.
REQ-023 level SHALL saturate at 0 and at 2**DEPTH_W, and SHALL never wrap.

Reset
REQ-024 tb_rst SHALL force: FSM to IDLE, out_valid=0, out_data=0, fifo_rd_en=0, level=0, RR priority to requester 0, and all statistics counters to 0.
REQ-025 Reset asserted mid-HOLD SHALL drop out_valid immediately; an undelivered descriptor is discarded, because the FIFO is reset by the same tb_rst.

Configuration
REQ-026 With macro RD_ADDR_SCHED_STATS_EN defined, the block SHALL add output ports acc_cnt0 and acc_cnt1 (16 bits each, accepted descriptors per requester) and stall_cnt (16 bits, cycles with any req_valid=1 but no grant due to almost_full or wr_full); all three SHALL saturate at 16'hFFFF.
REQ-027 Without RD_ADDR_SCHED_STATS_EN, those ports and counters SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-028 Package rd_addr_sched_pkg SHALL hold the FSM state enum (IDLE, FETCH, HOLD) and the default DATA_W and DEPTH_W constants.
REQ-029 The two-way round-robin arbiter SHALL be sub-module rr_arb2, with inputs req[1:0] and enable, and output grant[1:0] (one-hot or zero).

Verification
REQ-030 Bench: after reset, req_valid=2'b11 held for 4 cycles with FIFO empty -> grants alternate 0,1,0,1 and fifo_wr_en=1 on each of those cycles.
REQ-031 Bench: fill 63 descriptors and model fifo_almost_full=1 -> req_ready=0, fifo_wr_en=0, and with STATS_EN stall_cnt counts every stalled cycle.
REQ-032 Bench: write 0xFFFF_FFFF_FFFF_FFFF then 0xFFFF_FFFF_FFFF_FFFE, with out_ready=1 -> out_data delivers them in order; first out_valid 2 cycles after fifo_rd_empty falls.
REQ-033 Bench: out_ready=0 for 10 cycles in HOLD -> out_data stable, fifo_rd_en=0, level unchanged.
REQ-034 Bench: simultaneous write and read at level=5 -> level stays 5; a read at level=0 -> no fifo_rd_en and level stays 0.
REQ-035 Bench: assert tb_rst during HOLD -> out_valid=0 and level=0 in the same cycle, then normal operation after release.
